// File: rtl/endp_flit_injector_pkg.sv
// Shared types and helpers for the endpoint flit injector: FSM states,
// head-flit field placement and credit counter sizing.
package endp_flit_injector_pkg;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY
    } inj_state_e;

    // Head flit layout, LSB first: dest | src | size, zero padded above.
    localparam int HDR_DEST_OFS = 0;

    function automatic int hdr_src_ofs(input int eaw);
        return eaw;
    endfunction

    function automatic int hdr_size_ofs(input int eaw);
        return 2 * eaw;
    endfunction

    function automatic int cred_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/endp_flit_injector_credit_ctr.sv
// One downstream-buffer credit counter; starts full at B and saturates
// at both ends.
module injector_credit_ctr
    import endp_flit_injector_pkg::*;
#(
    parameter int B  = 4,
    parameter int CW = cred_w(B)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          dec,
    input  logic          inc,
    output logic [CW-1:0] count,
    output logic          nz
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= CW'(B);
        end else if (inc && !dec) begin
            if (count != CW'(B)) count <= count + CW'(1);
        end else if (dec && !inc) begin
            if (count != '0) count <= count - CW'(1);
        end
    end

    assign nz = (count != '0);

    // A return beyond B means the router handed back a credit it never owed.
    assert property (@(posedge clk) disable iff (reset) !(inc && !dec && count == CW'(B)));
    assert property (@(posedge clk) disable iff (reset) !(dec && !inc && count == '0));

endmodule

// File: rtl/endp_flit_injector.sv
// Endpoint packet injector: splits descriptors plus payload words into
// head/body/tail flits and gates issue on per-VC downstream credits.
module endp_flit_injector
    import endp_flit_injector_pkg::*;
#(
    parameter int V       = 2,
    parameter int B       = 4,
    parameter int EAw     = 8,
    parameter int DATA_W  = 32,
    parameter int MAX_PCK = 16,
    parameter int SW      = $clog2(MAX_PCK + 1),
    parameter int SRC_ID  = 0,
    localparam int VCW    = (V > 1) ? $clog2(V) : 1,
    localparam int CW     = cred_w(B)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pkt_valid,
    output logic              pkt_ready,
    input  logic [EAw-1:0]    pkt_dest,
    input  logic [SW-1:0]     pkt_size,
    input  logic [VCW-1:0]    pkt_vc,
    input  logic              dat_valid,
    output logic              dat_ready,
    input  logic [DATA_W-1:0] dat,
    output logic              flit_wr,
    output logic              flit_hdr,
    output logic              flit_tail,
    output logic [V-1:0]      flit_vc,
    output logic [DATA_W-1:0] flit_data,
    input  logic [V-1:0]      credit_in,
    output logic              busy,
    output logic [31:0]       pkt_sent_cnt
);

    localparam logic [EAw-1:0] SRC_ADDR = EAw'(SRC_ID);
    localparam int SRC_OFS  = hdr_src_ofs(EAw);
    localparam int SIZE_OFS = hdr_size_ofs(EAw);

    inj_state_e        state, state_n;
    logic [EAw-1:0]    dest_q;
    logic [SW-1:0]     size_q;
    logic [SW-1:0]     rem;
    logic [VCW-1:0]    vc_q;
    logic [V-1:0]      vc_oh;
    logic [V-1:0]      cred_nz;
    logic [CW-1:0]     cred_cnt [V];
    logic              cur_nz;
    logic              issue;
    logic              is_hdr;
    logic              is_tail;
    logic [DATA_W-1:0] head_word;
    logic [DATA_W-1:0] data_n;

    assign vc_oh     = V'(1) << vc_q;
    assign cur_nz    = cred_nz[vc_q];
    assign pkt_ready = (state == IDLE);
    assign busy      = (state != IDLE);
    assign head_word = (DATA_W'(dest_q) << HDR_DEST_OFS)
                     | (DATA_W'(SRC_ADDR) << SRC_OFS)
                     | (DATA_W'(size_q) << SIZE_OFS);

    always_comb begin
        state_n   = state;
        issue     = 1'b0;
        is_hdr    = 1'b0;
        is_tail   = 1'b0;
        data_n    = dat;
        dat_ready = 1'b0;
        case (state)
            IDLE: if (pkt_valid) state_n = HEAD;
            HEAD: begin
                if (cur_nz) begin
                    issue  = 1'b1;
                    is_hdr = 1'b1;
                    data_n = head_word;
                    if (size_q == SW'(1)) begin
                        is_tail = 1'b1;
                        state_n = IDLE;
                    end else begin
                        state_n = BODY;
                    end
                end
            end
            BODY: begin
                if (cur_nz && dat_valid) begin
                    issue     = 1'b1;
                    dat_ready = 1'b1;
                    if (rem == SW'(1)) begin
                        is_tail = 1'b1;
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    // Descriptor latch and remaining-flit count; always written before use.
    always_ff @(posedge clk) begin
        if (pkt_valid && pkt_ready) begin
            dest_q <= pkt_dest;
            size_q <= (pkt_size == '0) ? SW'(1) : pkt_size;
            vc_q   <= pkt_vc;
        end
        if (issue && state == HEAD)      rem <= size_q - SW'(1);
        else if (issue && state == BODY) rem <= rem - SW'(1);
    end

    // Output flit register stage.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            flit_wr      <= 1'b0;
            flit_hdr     <= 1'b0;
            flit_tail    <= 1'b0;
            flit_vc      <= '0;
            flit_data    <= '0;
            pkt_sent_cnt <= '0;
        end else begin
            flit_wr <= issue;
            if (issue) begin
                flit_hdr  <= is_hdr;
                flit_tail <= is_tail;
                flit_vc   <= vc_oh;
                flit_data <= data_n;
            end
            if (issue && is_tail) pkt_sent_cnt <= pkt_sent_cnt + 32'd1;
        end
    end

    for (genvar v = 0; v < V; v++) begin : g_cred
        injector_credit_ctr #(
            .B  (B),
            .CW (CW)
        ) u_ctr (
            .clk   (clk),
            .reset (reset),
            .dec   (issue && (vc_q == VCW'(v))),
            .inc   (credit_in[v]),
            .count (cred_cnt[v]),
            .nz    (cred_nz[v])
        );

        assert property (@(posedge clk) disable iff (reset) cred_cnt[v] <= CW'(B));
    end

endmodule

// File: tb/tb_endp_flit_injector.sv
// Scoreboard bench for endp_flit_injector: packets are expanded into expected
// flits at acceptance, a negedge monitor pops and compares, and a model router
// returns credits.
module tb_endp_flit_injector;

    localparam int V       = 2;
    localparam int B       = 4;
    localparam int EAw     = 8;
    localparam int DATA_W  = 32;
    localparam int MAX_PCK = 16;
    localparam int SW      = 5;
    localparam int VCW     = 1;
    localparam int SRC_ID  = 0;

    logic              clk = 1'b0;
    logic              reset;
    logic              pkt_valid;
    logic              pkt_ready;
    logic [EAw-1:0]    pkt_dest;
    logic [SW-1:0]     pkt_size;
    logic [VCW-1:0]    pkt_vc;
    logic              dat_valid;
    logic              dat_ready;
    logic [DATA_W-1:0] dat;
    logic              flit_wr;
    logic              flit_hdr;
    logic              flit_tail;
    logic [V-1:0]      flit_vc;
    logic [DATA_W-1:0] flit_data;
    logic [V-1:0]      credit_in;
    logic              busy;
    logic [31:0]       pkt_sent_cnt;

    endp_flit_injector #(
        .V(V), .B(B), .EAw(EAw), .DATA_W(DATA_W), .MAX_PCK(MAX_PCK), .SW(SW), .SRC_ID(SRC_ID)
    ) dut (
        .clk(clk), .reset(reset),
        .pkt_valid(pkt_valid), .pkt_ready(pkt_ready), .pkt_dest(pkt_dest),
        .pkt_size(pkt_size), .pkt_vc(pkt_vc),
        .dat_valid(dat_valid), .dat_ready(dat_ready), .dat(dat),
        .flit_wr(flit_wr), .flit_hdr(flit_hdr), .flit_tail(flit_tail),
        .flit_vc(flit_vc), .flit_data(flit_data),
        .credit_in(credit_in), .busy(busy), .pkt_sent_cnt(pkt_sent_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              hdr;
        logic              tail;
        logic [V-1:0]      vc;
        logic [DATA_W-1:0] data;
    } flit_t;

    flit_t             expq[$];
    logic [DATA_W-1:0] dq[$];
    int checks = 0;
    int errors = 0;
    int outstanding[V];
    int exp_sent = 0;
    int seen = 0;
    int run = 0;
    int last_run = 0;
    int pulse_req = 0;
    int pulse_done = 0;
    bit auto_credit = 1'b0;
    bit allow_gap = 1'b0;
    bit hold = 1'b0;

    // Monitor plus model router: compares flits and hands credits back.
    always @(negedge clk) begin
        flit_t exp_f;
        flit_t got_f;
        int    vi;
        if (reset) begin
            expq.delete();
            for (int v = 0; v < V; v++) outstanding[v] = 0;
            exp_sent   = 0;
            run        = 0;
            credit_in  = '0;
            pulse_done = pulse_req;
        end else begin
            if (flit_wr) begin
                seen++;
                run++;
                got_f = {flit_hdr, flit_tail, flit_vc, flit_data};
                checks++;
                if (expq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_flit got %h", got_f);
                end else begin
                    exp_f = expq.pop_front();
                    if (got_f !== exp_f) begin
                        errors++;
                        $display("FAIL flit got %h expected %h", got_f, exp_f);
                    end
                end
                vi = (flit_vc == 2'b10) ? 1 : 0;
                outstanding[vi]++;
                checks++;
                if (outstanding[vi] > B) begin
                    errors++;
                    $display("FAIL credit_overrun vc %0d occupancy %0d limit %0d", vi, outstanding[vi], B);
                end
                if (flit_tail) begin
                    exp_sent++;
                    last_run = run;
                    checks++;
                    if (pkt_sent_cnt !== 32'(exp_sent)) begin
                        errors++;
                        $display("FAIL pkt_sent_cnt got %0d expected %0d", pkt_sent_cnt, exp_sent);
                    end
                end
            end else begin
                run = 0;
            end
            credit_in = '0;
            if (pulse_req != pulse_done && outstanding[0] > 0) begin
                credit_in[0] = 1'b1;
                outstanding[0]--;
                pulse_done++;
            end else if (auto_credit) begin
                for (int v = 0; v < V; v++) begin
                    if (outstanding[v] > 0 && $urandom_range(2) == 0) begin
                        credit_in[v] = 1'b1;
                        outstanding[v]--;
                    end
                end
            end
        end
    end

    always @(posedge clk) begin
        if (reset) dq.delete();
        else if (dat_valid && dat_ready) void'(dq.pop_front());
    end

    always @(negedge clk) begin
        if (reset || hold || dq.size() == 0) begin
            dat_valid = 1'b0;
            dat       = $urandom;
        end else if (allow_gap && $urandom_range(3) == 0) begin
            dat_valid = 1'b0;
            dat       = $urandom;
        end else begin
            dat_valid = 1'b1;
            dat       = dq[0];
        end
    end

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, expv);
        end
    endtask

    task automatic send(input logic [EAw-1:0] d, input int sz, input int vc);
        int                eff;
        int                waited;
        flit_t             f;
        logic [DATA_W-1:0] w;
        eff    = (sz == 0) ? 1 : sz;
        waited = 0;
        @(negedge clk);
        pkt_valid = 1'b1;
        pkt_dest  = d;
        pkt_size  = SW'(sz);
        pkt_vc    = VCW'(vc);
        while (!pkt_ready && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        if (!pkt_ready) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout waited %0d cycles", waited);
            pkt_valid = 1'b0;
            return;
        end
        f.hdr  = 1'b1;
        f.tail = (eff == 1);
        f.vc   = V'(1) << vc;
        f.data = DATA_W'(d) + DATA_W'(SRC_ID) * 256 + DATA_W'(eff) * 65536;
        expq.push_back(f);
        for (int i = 1; i < eff; i++) begin
            w = $urandom;
            dq.push_back(w);
            f.hdr  = 1'b0;
            f.tail = (i == eff - 1);
            f.data = w;
            expq.push_back(f);
        end
        @(negedge clk);
        pkt_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((expq.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        #1;
        checks++;
        if (expq.size() != 0 || busy) begin
            errors++;
            $display("FAIL drain_timeout pending %0d busy %0d", expq.size(), busy);
        end
    endtask

    initial begin
        int s0;
        int n;
        reset     = 1'b1;
        pkt_valid = 1'b0;
        pkt_dest  = '0;
        pkt_size  = '0;
        pkt_vc    = '0;
        #1;
        chk("ready_in_reset", 64'(pkt_ready), 64'd1);
        chk("busy_in_reset", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        chk("reset_flit_regs", 64'({flit_wr, flit_hdr, flit_tail, flit_vc, flit_data}), 64'd0);
        chk("reset_sent_cnt", 64'(pkt_sent_cnt), 64'd0);
        reset = 1'b0;

        // Single-flit packet on VC1, no credit return.
        send(8'd5, 1, 1);
        repeat (4) @(negedge clk);
        #1;
        chk("single_flit_count", 64'(seen), 64'd1);
        chk("single_sent_cnt", 64'(pkt_sent_cnt), 64'd1);

        // Four-flit packet on VC0 drains all of VC0's credit.
        send(8'h33, 4, 0);
        drain();
        chk("back_to_back_run", 64'(last_run), 64'd4);

        // Second VC0 packet must wait for a returned credit.
        s0 = seen;
        send(8'h44, 2, 0);
        repeat (10) @(negedge clk);
        #1;
        chk("stall_no_flit", 64'(seen), 64'(s0));
        chk("stall_busy", 64'(busy), 64'd1);
        @(posedge clk);
        pulse_req++;
        @(negedge clk);
        @(negedge clk);
        #1;
        chk("head_not_early", 64'(seen), 64'(s0));
        @(negedge clk);
        #1;
        chk("head_after_credit", 64'(seen), 64'(s0 + 1));
        auto_credit = 1'b1;
        drain();
        chk("sent_after_stall", 64'(pkt_sent_cnt), 64'd3);

        // Zero size becomes a single head+tail flit with size field 1.
        send(8'h7e, 0, 1);
        drain();
        chk("size0_sent", 64'(pkt_sent_cnt), 64'd4);

        // Randomized traffic with payload gaps and credit jitter.
        allow_gap = 1'b1;
        repeat (40) begin
            send(EAw'($urandom), ($urandom_range(3) == 0) ? $urandom_range(0, MAX_PCK) : $urandom_range(0, 5),
                 $urandom_range(V - 1));
            repeat ($urandom_range(2)) @(negedge clk);
        end
        drain();
        chk("random_sent", 64'(pkt_sent_cnt), 64'(exp_sent));

        // Abort a packet in BODY with two flits still to go.
        allow_gap = 1'b0;
        hold      = 1'b1;
        s0        = seen;
        send(8'h21, 4, 0);
        n = 0;
        while (seen < s0 + 1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        hold = 1'b0;
        @(posedge clk);
        #1;
        hold = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("pre_abort_flits", 64'(seen), 64'(s0 + 2));
        chk("pre_abort_busy", 64'(busy), 64'd1);
        #2;
        reset = 1'b1;
        #1;
        chk("abort_flit_regs", 64'({flit_wr, flit_hdr, flit_tail, flit_vc, flit_data}), 64'd0);
        chk("abort_ctrl", 64'({busy, pkt_ready}), 64'b01);
        chk("abort_sent_cnt", 64'(pkt_sent_cnt), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        hold  = 1'b0;

        // Full credits restored: a 4-flit packet runs without a stall.
        auto_credit = 1'b0;
        send(8'h99, 4, 0);
        drain();
        chk("post_reset_run", 64'(last_run), 64'd4);
        chk("post_reset_sent", 64'(pkt_sent_cnt), 64'd1);
        auto_credit = 1'b1;
        allow_gap   = 1'b1;
        repeat (10) send(EAw'($urandom), $urandom_range(0, 6), $urandom_range(V - 1));
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/endp_flit_injector.md
# endp_flit_injector

Endpoint-side packet injector for one NoC endpoint. Accepts packet descriptors and payload words from the local core, splits each packet into head/body/tail flits, and drives them into that endpoint's slot of the NoC input channel array. Tracks downstream buffer space per virtual channel with credit counters, so the router input port never overflows. One instance sits directly upstream of each endpoint input of the NoC top.

## Interface
- V, 2: number of virtual channels.
- B, 4: router input buffer depth per VC, in flits; also the initial credit count.
- EAw, 8: endpoint address width.
- DATA_W, 32: flit payload width.
- MAX_PCK, 16: maximum packet size in flits, head included.
- SW, $clog2(MAX_PCK+1): packet size field width.
- SRC_ID, 0: this endpoint's address.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high.
- pkt_valid  in  1  packet descriptor valid.
- pkt_ready  out  1  descriptor accepted when valid & ready at a rising edge.
- pkt_dest  in  EAw  destination endpoint address.
- pkt_size  in  SW  flits in packet; 0 is treated as 1.
- pkt_vc  in  $clog2(V)  VC to use, binary.
- dat_valid  in  1  body payload word valid.
- dat_ready  out  1  payload word consumed this cycle.
- dat  in  DATA_W  body payload.
- flit_wr  out  1  flit valid, registered.
- flit_hdr  out  1  head flag.
- flit_tail  out  1  tail flag.
- flit_vc  out  V  one-hot VC of the flit.
- flit_data  out  DATA_W  head: {zero-pad, pkt_size, SRC_ID, pkt_dest} LSB-aligned; body/tail: dat.
- credit_in  in  V  one credit returned per asserted bit per cycle.
- busy  out  1  state != IDLE.
- pkt_sent_cnt  out  32  packets whose tail has been issued; wraps.

## Operation
- FSM states:
  - IDLE: pkt_ready=1. On accept, latch dest, size (0→1), and vc, then go to HEAD.
  - HEAD: if cred[vc]>0, issue the head flit. If size==1, the flit also has flit_tail=1 and the FSM returns to IDLE. Otherwise rem=size-1 and the FSM goes to BODY. With no credit, it stays in HEAD.
  - BODY: if cred[vc]>0 and dat_valid, then dat_ready=1, issue a flit with data=dat, and decrement rem. If rem==1 at issue, set flit_tail=1 and return to IDLE.
- dat_ready is combinational: (state==BODY) & dat_valid & (cred[vc]>0).
- "Issue" means the output registers load the flit at the next edge. Otherwise flit_wr loads 0 and the other flit fields hold their values.
- Credit counters: one per VC, width $clog2(B+1), reset to B.
  - Issue on VC v decrements cred[v]; credit_in[v] increments it.
  - Issue and credit on the same VC in the same cycle leaves the count unchanged.
  - A counter exceeding B is an assertion failure; it must not wrap.
- pkt_sent_cnt increments on the edge where a tail, or a single-flit head, is issued.
- A VC with zero credits blocks only the current packet. No reordering and no interleaving of packets.

## Timing
- Reset values: state IDLE, flit_wr 0, flit_hdr 0, flit_tail 0, flit_vc 0, flit_data 0, cred[*]=B, pkt_sent_cnt 0. pkt_ready is 1 during and after reset; busy is 0.
- Descriptor accepted at edge E0 → head flit on the outputs in the cycle after E1, if credit is available.
- With full credits and continuous dat_valid, a packet of N flits occupies N consecutive flit_wr cycles.
- Next packet: pkt_ready rises in the cycle after the tail is issued, giving a one-cycle gap between packets.
- Credits arriving at edge k are usable for issue decisions in the cycle after edge k.
- Asserting reset mid-packet aborts immediately to reset values and drops the partial packet. The router shares the same reset, so no recovery is needed.

## Structure
- The shared package holds:
  - the head-flit field layout (offsets of dest, src, size);
  - the FSM state enum {IDLE, HEAD, BODY};
  - the credit width function.
- Sub-module injector_credit_ctr: one credit counter. Ports: clk, reset, dec, inc, count, nz. Generated V times.
- The wrapper that packs flit_* and credit_in into the endpoint channel struct lives outside this block.

## Test plan
- Single-flit packet: V=2, pkt_size=1, pkt_vc=1, dest 5 → one flit with hdr=1, tail=1, flit_vc=2'b10, data[7:0]=5; cred[1] goes 4→3; pkt_sent_cnt=1.
- 4-flit packet on VC0, no credit return, dat=A,B,C → flits H,A,B,C(tail) on 4 consecutive cycles; cred[0]=0. A second packet on VC0 stalls in HEAD until one credit_in[0] pulse, then the head is issued 2 cycles after the pulse.
- Simultaneous issue and credit_in on the same VC for 10 cycles → the counter holds constant and never exceeds 4.
- dat_valid deasserted for 3 cycles mid-packet → flit_wr is 0 for those cycles, no data is duplicated, and the tail is still correct.
- pkt_size=0 → treated as a single head+tail flit with the size field = 1.
- Reset asserted while in BODY with rem=2 → outputs return to reset values on the same cycle (asynchronously), cred[*]=4, and the next packet is injected correctly.
